// File: rtl/priority_encoder_8to3_pkg.sv
// Shared constants for the 8-to-3 priority encoder.
//   CODE_W      : width of the encoded index
//   NUM_IN      : number of request lines
//   NO_REQ_CODE : code presented when no line is asserted
package priority_encoder_8to3_pkg;

   localparam int CODE_W = 3;
   localparam int NUM_IN = 8;

   localparam logic [CODE_W-1:0] NO_REQ_CODE = 3'b000;

endpackage

// File: rtl/priority_encoder_core.sv
// Combinational fixed-priority encoder, I7 highest, I0 lowest.
//   I0..I7 : request lines
//   code   : index of highest asserted line (NO_REQ_CODE when none)
//   any    : 1 when at least one line is asserted
module priority_encoder_core
   import priority_encoder_8to3_pkg::*;
(
   input  logic              I0,
   input  logic              I1,
   input  logic              I2,
   input  logic              I3,
   input  logic              I4,
   input  logic              I5,
   input  logic              I6,
   input  logic              I7,
   output logic [CODE_W-1:0] code,
   output logic              any
);

   always_comb begin
      code = NO_REQ_CODE;
      any  = I0 | I1 | I2 | I3 | I4 | I5 | I6 | I7;
      // Chain ordered from highest line down so higher lines mask lower ones.
      if      (I7) code = 3'd7;
      else if (I6) code = 3'd6;
      else if (I5) code = 3'd5;
      else if (I4) code = 3'd4;
      else if (I3) code = 3'd3;
      else if (I2) code = 3'd2;
      else if (I1) code = 3'd1;
      else if (I0) code = 3'd0;
   end

endmodule

// File: rtl/priority_encoder_8to3.sv
// 8-input priority encoder with registered outputs (1-cycle latency).
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset, clears Y and V at once
//   I0..I7 : request lines, I7 highest priority
//   Y      : registered index of highest asserted line
//   V      : registered valid, 1 when any line was asserted
module priority_encoder_8to3
   import priority_encoder_8to3_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              I0,
   input  logic              I1,
   input  logic              I2,
   input  logic              I3,
   input  logic              I4,
   input  logic              I5,
   input  logic              I6,
   input  logic              I7,
   output logic [CODE_W-1:0] Y,
   output logic              V
);

   logic [CODE_W-1:0] code;
   logic              any;

   priority_encoder_core u_core (
      .I0   (I0),
      .I1   (I1),
      .I2   (I2),
      .I3   (I3),
      .I4   (I4),
      .I5   (I5),
      .I6   (I6),
      .I7   (I7),
      .code (code),
      .any  (any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Y <= NO_REQ_CODE;
         V <= 1'b0;
      end else begin
         Y <= code;
         V <= any;
      end
   end

endmodule

// File: tb/tb_priority_encoder_8to3.sv
module tb_priority_encoder_8to3;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [2:0] Y;
   logic       V;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] in;
      logic [2:0] y;
      logic       v;
   } vec_t;

   priority_encoder_8to3 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .I0    (req[0]),
      .I1    (req[1]),
      .I2    (req[2]),
      .I3    (req[3]),
      .I4    (req[4]),
      .I5    (req[5]),
      .I6    (req[6]),
      .I7    (req[7]),
      .Y     (Y),
      .V     (V)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: index of highest set bit is floor(log2(v)) = clog2(v+1)-1.
   function automatic logic [2:0] ref_y(input logic [7:0] v);
      int n;
      n = int'(v);
      if (n == 0) return 3'd0;
      return 3'($clog2(n + 1) - 1);
   endfunction

   task automatic check(input string name, input logic [2:0] ey, input logic ev);
      checks++;
      if (Y !== ey || V !== ev) begin
         failures++;
         $display("FAIL %s: got Y=%0d V=%0b expected Y=%0d V=%0b", name, Y, V, ey, ev);
      end
   endtask

   // Drive between edges, then sample 1 time unit after the capturing edge.
   task automatic apply(input logic [7:0] v, input string name);
      @(negedge clk);
      req = v;
      @(posedge clk);
      #1;
      check(name, ref_y(v), v != 8'h00);
   endtask

   vec_t tbl [$];

   initial begin
      vec_t e;
      logic [7:0] r;

      rst_n = 1'b1;
      req   = 8'hFF;

      // Load nonzero state, then assert reset between edges.
      repeat (2) @(posedge clk);
      #1;
      check("preload_ff", 3'd7, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_async", 3'd0, 1'b0);
      @(posedge clk);
      #1;
      check("reset_hold_edge", 3'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset_release_noedge", 3'd0, 1'b0);
      @(posedge clk);
      #1;
      check("reset_first_edge", 3'd7, 1'b1);

      // Directed table with hand-derived expectations.
      tbl.push_back('{8'h00,       3'd0, 1'b0});
      for (int k = 0; k < 8; k++) begin
         e.in = 8'h00;
         e.in[k] = 1'b1;
         e.y = 3'(k);
         e.v = 1'b1;
         tbl.push_back(e);
      end
      tbl.push_back('{8'b0101_0110, 3'd6, 1'b1});
      tbl.push_back('{8'b0000_0011, 3'd1, 1'b1});
      tbl.push_back('{8'b1000_0001, 3'd7, 1'b1});
      tbl.push_back('{8'h00,        3'd0, 1'b0});

      foreach (tbl[i]) begin
         @(negedge clk);
         req = tbl[i].in;
         @(posedge clk);
         #1;
         check($sformatf("table[%0d] in=%02h", i, tbl[i].in), tbl[i].y, tbl[i].v);
      end

      // Exhaustive back-to-back sweep with a reset pulse in the middle.
      for (int i = 0; i < 256; i++) begin
         if (i == 100) begin
            #2;
            rst_n = 1'b0;
            #1;
            check("midstream_reset_async", 3'd0, 1'b0);
            @(negedge clk);
            rst_n = 1'b1;
         end
         apply(8'(i), $sformatf("sweep in=%02h", i));
      end

      // Random stimulus.
      for (int i = 0; i < 200; i++) begin
         r = 8'($urandom);
         if (i % 4 == 0) r = r >> $urandom_range(0, 7);
         apply(r, $sformatf("rand in=%02h", r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/priority_encoder_8to3.md
# priority_encoder_8to3

8-input priority encoder with registered outputs. Reports the index of the highest-numbered asserted request line on a 3-bit code, plus a valid flag that is high when any line is asserted. Used as a request/interrupt arbiter front-end. Inputs are individual scalar lines. Outputs are flops clocked by the single system clock and cleared by the asynchronous active-low reset.

## Interface
- No parameters. Width is fixed at 8 inputs and 3 code bits.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- I0  input  1  request line 0, lowest priority.
- I1  input  1  request line 1.
- I2  input  1  request line 2.
- I3  input  1  request line 3.
- I4  input  1  request line 4.
- I5  input  1  request line 5.
- I6  input  1  request line 6.
- I7  input  1  request line 7, highest priority.
- Y  output  3  registered binary index of the highest asserted line.
- V  output  1  registered valid flag; 1 when any of I0..I7 was 1.

## Operation
- Combinational encode stage:
  - code = largest k in 0..7 with Ik = 1.
  - any = I0 | I1 | … | I7.
- Priority is strictly fixed: I7 > I6 > … > I0. Lower lines are ignored whenever a higher line is set.
- When no line is asserted: code = 3'b000, any = 0. Y = 0 with V = 0 means "no request". Y = 0 with V = 1 means "I0 only".
- Register stage: on each rising clk, Y <= code and V <= any.
- No enable, no hold, and no handshake. A new result is presented every cycle.
- Inputs are treated as synchronous to clk; no internal synchronizers.
- X/Z on inputs is outside the contract. The implementation must not latch; all paths are fully assigned.

## Timing
- Latency: exactly 1 clock. Inputs present before rising edge n appear on Y/V after edge n, and stay stable until edge n+1.
- Throughput: one encode per cycle. Back-to-back changes are each reflected in the following cycle.
- Reset assertion (rst_n falls): Y = 3'b000 and V = 0 immediately, independent of clk. This holds even mid-stream; any in-flight result is discarded.
- While rst_n = 0, outputs stay 0 regardless of clk and inputs.
- Reset release: the first capture happens at the first rising clk with rst_n = 1. rst_n should be deasserted synchronously to clk.
- Simultaneous inputs: any number of lines may be high together; only the highest index is encoded.

## Structure
- A shared package is not required.
- If the team package is used, it holds:
  - the code width constant (3);
  - the input count (8);
  - the no-request code value (3'b000).
- One combinational sub-module is natural: priority_encoder_core.
  - Ports: I0..I7 in; code[2:0] and any out.
  - Pure casez/if-chain logic, no clock.
- The top level instantiates the core and adds the two output registers with asynchronous clear.

## Test plan
- Reset: drive rst_n = 0 with inputs 8'hFF (I7..I0) → Y = 0, V = 0 without a clock edge. Release rst_n, then 1 edge → Y = 7, V = 1.
- No request: inputs 8'h00, 1 edge → Y = 0, V = 0.
- One-hot sweep: for k = 0..7, drive only Ik = 1 → after 1 edge, Y = k and V = 1.
- Priority overlap:
  - 8'b0101_0110 → Y = 6, V = 1.
  - 8'b0000_0011 → Y = 1.
  - 8'b1000_0001 → Y = 7.
- Exhaustive: apply all 256 values of {I7..I0} on consecutive cycles. On each following cycle, check Y = floor(log2(value)) for nonzero values, with V = (value != 0). Check Y = 0, V = 0 for value 0.
- Mid-stream reset: during the sweep, pulse rst_n low between edges → outputs go to 0 at once. Encoding resumes correctly one edge after release.
